sample_capture: RTL and testbench
=================================

// Module: sample_capture
// PURPOSE
//  Upstream stage of the readout path: samples the 8-bit ADC bus at a divided rate, waits for a level
//  trigger (or auto-trigger timeout) and writes DEPTH consecutive samples into sample memory at
//  addresses 0..DEPTH-1. The trigger sample is written to address 0. Raises done when the buffer is full.
//  The sample reader then streams that memory out over the UART.
// PARAMETERS
//  DIV           50       clk_50mhz cycles per sample tick (>=2); 50 -> 1 MS/s
//  DEPTH         256      samples per capture (<=256, fits 8-bit mem_addr)
//  AUTO_TIMEOUT  1000000  sample ticks in WAIT_TRIG before a forced trigger (when auto_en=1)
// PORTS
//  clk_50mhz     in   1  system clock, all logic on rising edge
//  reset         in   1  asynchronous, active-low reset (0 = reset)
//  activate      in   1  level; 1 = arm and run a capture, 0 = abort / release done
//  done          out  1  1 = DEPTH samples written; held until activate=0
//  busy          out  1  1 in ARM, WAIT_TRIG or CAPTURE
//  adc_data      in   8  ADC sample bus, unsigned, synchronous to clk_50mhz
//  trig_level    in   8  trigger threshold, unsigned; sampled when leaving IDLE
//  trig_falling  in   1  0 = rising-edge trigger, 1 = falling; sampled when leaving IDLE
//  auto_en       in   1  1 = enable auto-trigger timeout; sampled when leaving IDLE
//  auto_trig     out  1  1 = last capture was started by timeout, not by level crossing
//  mem_addr      out  8  sample memory write address
//  mem_data      out  8  sample memory write data
//  mem_we        out  1  write strobe, one cycle per sample
// BEHAVIOUR
//  Reset: state=IDLE; done, busy, auto_trig, mem_we = 0; mem_addr, mem_data = 0; all counters = 0.
//  Tick: div_cnt counts 0..DIV-1, tick=1 for the one cycle div_cnt==DIV-1. div_cnt is held at 0 in IDLE,
//   so the first tick comes DIV cycles after leaving IDLE.
//  Write: on a CAPTURE tick, register mem_addr<=wr_ptr, mem_data<=adc_data, mem_we<=1.
//   mem_we is high exactly 1 cycle, in the cycle after the tick. mem_we=0 in every other cycle.
//  States:
//   IDLE: done=0. activate=1 -> ARM; latch trig_level, trig_falling and auto_en; clear auto_trig,
//     wr_ptr and the timeout counter.
//   ARM: first tick -> prev<=adc_data, go to WAIT_TRIG. No write in this state.
//   WAIT_TRIG: on each tick, cur=adc_data.
//     rising:  prev<level && cur>=level -> trigger.
//     falling: prev>level && cur<=level -> trigger.
//     Else, if auto_en and tmo_cnt==AUTO_TIMEOUT-1 -> trigger with auto_trig<=1.
//     Else tmo_cnt++ and prev<=cur.
//     On trigger: write cur at address 0, wr_ptr<=1, go to CAPTURE (same tick).
//   CAPTURE: each tick writes adc_data at wr_ptr, then wr_ptr++. The tick that writes address DEPTH-1
//     -> DONE.
//   DONE: done=1, busy=0. Stay until activate=0, then IDLE (done falls in the cycle IDLE is entered).
//  Abort: activate=0 in ARM, WAIT_TRIG or CAPTURE -> IDLE next cycle. No further mem_we, done stays 0,
//   and memory contents are undefined.
//  Level-equality edge cases: rising with prev==level never triggers. A constant input never triggers.
//  Widths: wr_ptr is 9 bits internally, so DEPTH=256 compares without wrap. tmo_cnt is
//   $clog2(AUTO_TIMEOUT) bits and saturates when auto_en=0.
//  Async reset mid-capture: immediate return to the reset values above; the next capture needs a fresh
//   activate rising level.
// TESTING
//  1 DIV=4, DEPTH=8, rising, level=0x80, ramp adc 0x70,0x7F,0x80,0x81.. -> first write addr0=0x80,
//    then addr1..7 = following samples. mem_we pulses are 4 cycles apart; done=1 after addr7.
//  2 Falling, level=0x40, adc 0x50,0x40 -> trigger on 0x40. Same stream with rising -> no trigger,
//    busy stays 1.
//  3 auto_en=1, AUTO_TIMEOUT=16, adc constant 0x10 -> trigger on tick 17 after ARM, auto_trig=1,
//    8 writes of 0x10.
//  4 activate dropped mid-CAPTURE after addr3 -> IDLE next cycle, no more mem_we, done=0.
//    Re-activate -> capture restarts at addr0.
//  5 done held while activate=1 for 100 cycles. activate=0 -> done=0 one cycle later.
//    Assert reset mid-WAIT_TRIG -> all outputs 0 at once.

Source files
------------

// File: rtl/sample_capture.sv
// Divided-rate ADC sampler: arms, waits for a level crossing (or auto-timeout),
// then writes DEPTH consecutive samples to sample memory starting at address 0.
`timescale 1ns/1ps
module sample_capture #(
  parameter int unsigned DIV          = 50,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned AUTO_TIMEOUT = 1000000
) (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic       activate,
  output logic       done,
  output logic       busy,
  input  logic [7:0] adc_data,
  input  logic [7:0] trig_level,
  input  logic       trig_falling,
  input  logic       auto_en,
  output logic       auto_trig,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_we
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TW = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam int unsigned PW = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_TRIG,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [PW-1:0]   wr_ptr;
  logic [TW-1:0]   tmo_cnt;
  logic [7:0]      prev;
  logic [7:0]      level_q;
  logic            falling_q;
  logic            auto_en_q;

  logic            tick_c;
  logic            level_hit_c;
  logic            timeout_hit_c;
  logic            last_wr_c;

  assign tick_c        = (div_cnt == DW'(DIV - 1));
  assign timeout_hit_c = auto_en_q && (tmo_cnt == TW'(AUTO_TIMEOUT - 1));
  assign last_wr_c     = (wr_ptr == PW'(DEPTH - 1));

  // Crossing test of the previous tick's sample against the current bus value.
  always_comb begin
    level_hit_c = 1'b0;
    if (falling_q) level_hit_c = (prev > level_q) && (adc_data <= level_q);
    else           level_hit_c = (prev < level_q) && (adc_data >= level_q);
  end

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      wr_ptr    <= '0;
      tmo_cnt   <= '0;
      prev      <= '0;
      level_q   <= '0;
      falling_q <= 1'b0;
      auto_en_q <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      auto_trig <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_we    <= 1'b0;
    end else begin
      mem_we <= 1'b0;

      // Sample-rate divider runs only while a capture is in flight.
      if (state == S_ARM || state == S_WAIT_TRIG || state == S_CAPTURE)
        div_cnt <= tick_c ? '0 : div_cnt + DW'(1);
      else
        div_cnt <= '0;

      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (activate) begin
            state     <= S_ARM;
            busy      <= 1'b1;
            level_q   <= trig_level;
            falling_q <= trig_falling;
            auto_en_q <= auto_en;
            auto_trig <= 1'b0;
            wr_ptr    <= '0;
            tmo_cnt   <= '0;
          end
        end
        S_ARM: begin
          if (!activate) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (tick_c) begin
            prev  <= adc_data;
            state <= S_WAIT_TRIG;
          end
        end
        S_WAIT_TRIG: begin
          if (!activate) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (tick_c) begin
            if (level_hit_c || timeout_hit_c) begin
              mem_addr  <= '0;
              mem_data  <= adc_data;
              mem_we    <= 1'b1;
              wr_ptr    <= PW'(1);
              auto_trig <= !level_hit_c;
              state     <= S_CAPTURE;
            end else begin
              if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TW'(1);
              prev <= adc_data;
            end
          end
        end
        S_CAPTURE: begin
          if (!activate) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (tick_c) begin
            mem_addr <= wr_ptr[7:0];
            mem_data <= adc_data;
            mem_we   <= 1'b1;
            wr_ptr   <= wr_ptr + PW'(1);
            if (last_wr_c) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (!activate) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture with DIV=4, DEPTH=8, AUTO_TIMEOUT=16.
`timescale 1ns/1ps
module tb_sample_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic       activate;
  logic       done;
  logic       busy;
  logic [7:0] adc_data;
  logic [7:0] trig_level;
  logic       trig_falling;
  logic       auto_en;
  logic       auto_trig;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_we;

  int checks   = 0;
  int failures = 0;

  sample_capture #(.DIV(4), .DEPTH(8), .AUTO_TIMEOUT(16)) dut (
    .clk_50mhz   (clk),
    .reset       (reset),
    .activate    (activate),
    .done        (done),
    .busy        (busy),
    .adc_data    (adc_data),
    .trig_level  (trig_level),
    .trig_falling(trig_falling),
    .auto_en     (auto_en),
    .auto_trig   (auto_trig),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_we      (mem_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One sample period: drive v, run 4 clocks, expect a lone mem_we only at the end.
  task automatic step(input logic [7:0] v, input logic we_exp,
                      input logic [7:0] a_exp, input logic [7:0] d_exp);
    logic stray;
    stray = 1'b0;
    adc_data = v;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3 && mem_we) stray = 1'b1;
    end
    chk("we_gap", {7'd0, stray}, 8'h00);
    chk("we", {7'd0, mem_we}, {7'd0, we_exp});
    if (we_exp) begin
      chk("addr", mem_addr, a_exp);
      chk("data", mem_data, d_exp);
    end
  endtask

  initial begin
    logic held;
    logic seen_we;
    reset = 1'b0; activate = 1'b0; adc_data = 8'h00;
    trig_level = 8'h80; trig_falling = 1'b0; auto_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done", {7'd0, done}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_we", {7'd0, mem_we}, 8'h00);
    chk("rst_addr", mem_addr, 8'h00);
    reset = 1'b1;
    @(negedge clk);

    // Rising ramp through 0x80.
    activate = 1'b1;
    @(negedge clk);
    chk("t1_busy", {7'd0, busy}, 8'h01);
    step(8'h70, 1'b0, 8'h00, 8'h00);
    step(8'h7F, 1'b0, 8'h00, 8'h00);
    step(8'h80, 1'b1, 8'h00, 8'h80);
    for (int k = 1; k < 8; k++) begin
      if (k == 7) chk("t1_done_early", {7'd0, done}, 8'h00);
      step(8'h80 + 8'(k), 1'b1, 8'(k), 8'h80 + 8'(k));
    end
    chk("t1_done", {7'd0, done}, 8'h01);
    chk("t1_busy_end", {7'd0, busy}, 8'h00);
    chk("t1_auto", {7'd0, auto_trig}, 8'h00);

    // done held while activate stays high, then drops one cycle after release.
    held = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (!done || mem_we) held = 1'b0;
    end
    chk("t5_done_held", {7'd0, held}, 8'h01);
    activate = 1'b0;
    @(negedge clk);
    chk("t5_done_drop", {7'd0, done}, 8'h00);

    // Falling trigger at 0x40 on equality.
    trig_falling = 1'b1; trig_level = 8'h40;
    activate = 1'b1;
    @(negedge clk);
    step(8'h50, 1'b0, 8'h00, 8'h00);
    step(8'h40, 1'b1, 8'h00, 8'h40);
    activate = 1'b0;
    @(negedge clk);
    chk("t2_abort_busy", {7'd0, busy}, 8'h00);

    // Same stream with rising edge never triggers.
    trig_falling = 1'b0;
    activate = 1'b1;
    @(negedge clk);
    step(8'h50, 1'b0, 8'h00, 8'h00);
    step(8'h40, 1'b0, 8'h00, 8'h00);
    step(8'h40, 1'b0, 8'h00, 8'h00);
    step(8'h40, 1'b0, 8'h00, 8'h00);
    chk("t2_rise_busy", {7'd0, busy}, 8'h01);
    activate = 1'b0;
    @(negedge clk);

    // Auto-trigger on tick 17 with constant input.
    trig_level = 8'h80; auto_en = 1'b1;
    activate = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 16; k++) step(8'h10, 1'b0, 8'h00, 8'h00);
    step(8'h10, 1'b1, 8'h00, 8'h10);
    chk("t3_auto", {7'd0, auto_trig}, 8'h01);
    for (int k = 1; k < 8; k++) step(8'h10, 1'b1, 8'(k), 8'h10);
    chk("t3_done", {7'd0, done}, 8'h01);
    activate = 1'b0;
    auto_en = 1'b0;
    @(negedge clk);

    // Abort mid-capture after addr3, then restart at addr0.
    activate = 1'b1;
    @(negedge clk);
    step(8'h00, 1'b0, 8'h00, 8'h00);
    step(8'h90, 1'b1, 8'h00, 8'h90);
    chk("t4_auto", {7'd0, auto_trig}, 8'h00);
    step(8'h91, 1'b1, 8'h01, 8'h91);
    step(8'h92, 1'b1, 8'h02, 8'h92);
    step(8'h93, 1'b1, 8'h03, 8'h93);
    activate = 1'b0;
    seen_we = 1'b0;
    held = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (mem_we) seen_we = 1'b1;
      if (done) held = 1'b1;
    end
    chk("t4_no_we", {7'd0, seen_we}, 8'h00);
    chk("t4_no_done", {7'd0, held}, 8'h00);
    chk("t4_busy", {7'd0, busy}, 8'h00);
    activate = 1'b1;
    @(negedge clk);
    step(8'h00, 1'b0, 8'h00, 8'h00);
    step(8'hA0, 1'b1, 8'h00, 8'hA0);
    step(8'hA1, 1'b1, 8'h01, 8'hA1);
    activate = 1'b0;
    @(negedge clk);

    // Async reset while waiting for a trigger.
    activate = 1'b1;
    @(negedge clk);
    step(8'h00, 1'b0, 8'h00, 8'h00);
    step(8'h10, 1'b0, 8'h00, 8'h00);
    chk("t5_pre_busy", {7'd0, busy}, 8'h01);
    reset = 1'b0;
    #1;
    chk("t5_rst_busy", {7'd0, busy}, 8'h00);
    chk("t5_rst_done", {7'd0, done}, 8'h00);
    chk("t5_rst_we", {7'd0, mem_we}, 8'h00);
    chk("t5_rst_addr", mem_addr, 8'h00);
    chk("t5_rst_data", mem_data, 8'h00);
    chk("t5_rst_auto", {7'd0, auto_trig}, 8'h00);
    activate = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_idle_busy", {7'd0, busy}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
